calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 num  input  4  hex digit from keypad detector; valid only in the cycle ok=1.
REQ-004 operation  input  5  latched operator code from detector; level, not pulse.
REQ-005 EXE  input  1  one-cycle execute pulse.
REQ-006 CE  input  1  one-cycle clear-entry pulse.
REQ-007 CLR  input  1  one-cycle clear-all pulse.
REQ-008 ok  input  1  one-cycle digit-valid pulse.
REQ-009 display  output  16  value to show: current entry or last result.
REQ-010 state  output  2  current FSM state code.
REQ-011 ovf  output  1  carry/borrow of last executed operation.

Function
REQ-012 Op codes SHALL be ADD=5'b1_0000, SUB=5'b1_0001, AND=5'b1_0100, OR=5'b1_0101; any other operation value is no operator.
REQ-013 An op event SHALL occur in a cycle where operation is a valid op code and differs from the registered value of operation from the previous cycle.
REQ-014 Input priority in one cycle SHALL be CLR > CE > EXE > ok > op event; lower-priority inputs in that cycle are ignored.
REQ-015 FSM states SHALL be ENTER_A=0, OP_SET=1, ENTER_B=2, RESULT=3.
REQ-016 Digit entry SHALL shift left 4 bits and insert num (operand = {operand[11:0], num}), with at most 4 digits per operand; ok events after the 4th digit are ignored.
REQ-017 ENTER_A: ok shifts into A; op event stores op and moves to OP_SET; EXE ignored; CE clears A and its digit count.
REQ-018 OP_SET: ok loads B=num with count=1 and moves to ENTER_B; op event replaces the stored op; CE drops the op and returns to ENTER_A with A kept; EXE ignored.
REQ-019 ENTER_B: ok shifts into B; EXE computes R=A op B and moves to RESULT; op event sets A=A op B (chaining), stores the new op and moves to OP_SET; CE clears B and its count.
REQ-020 RESULT: ok starts a new A=num, count=1, and moves to ENTER_A; op event sets A=R, stores op and moves to OP_SET; EXE ignored; CE clears to ENTER_A with A=0.
REQ-021 CLR in any state SHALL return all registers to reset values.
REQ-022 Arithmetic SHALL wrap modulo 2^16; ovf=carry-out for ADD, borrow (A<B) for SUB, 0 for AND/OR; ovf updates only on EXE or chaining and is cleared by CE/CLR.
REQ-023 display SHALL equal A in ENTER_A and OP_SET, B in ENTER_B, and R in RESULT.
REQ-024 All outputs SHALL be registered, reflecting an input event one clock after the input cycle.

Reset
REQ-025 On rst: state=ENTER_A, A=B=R=0, digit count=0, stored op=ADD, previous-operation register=0, display=0x0000, ovf=0.
REQ-026 rst asserted mid-entry or mid-chain SHALL abort the operation with no partial result retained.

Structure
REQ-027 Package calc_pkg SHALL hold the op-code constants, the EXE/CE/CLR codes (1_0011, 1_0110, 1_0111) and the FSM state enum.
REQ-028 A combinational sub-module calc_alu (A, B, op -> result[15:0], ovf) SHALL perform all arithmetic; calc_sequencer holds the FSM and registers.

Verification
REQ-029 ok num=1, ok num=2, ADD, ok 3, ok 4, EXE -> display 0x0012, then 0x0034, then 0x0046; state=3; ovf=0.
REQ-030 Digits F,F,F,F, ADD, digit 1, EXE -> display 0x0000, ovf=1; digits 2, SUB, 3, EXE -> 0xFFFF, ovf=1.
REQ-031 Digits 1,2,3,4,5 -> display 0x1234 (5th ignored); CE -> 0x0000, state=0.
REQ-032 5 SUB 2 ADD 1 EXE -> display 0x0003 after the ADD op event, 0x0004 after EXE.
REQ-033 Digits 7,8 then rst pulse mid-cycle -> display 0x0000, state=0 immediately; next digit 9 -> 0x0009.
REQ-034 Same-cycle CLR and ok num=5 from ENTER_B with B=0x0042 -> full reset, display 0x0000 (CLR wins).

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: key codes, FSM states and
// the operator-code qualifier.
package calc_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned OP_W       = 5;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned MAX_DIGITS = 4;

  typedef enum logic [OP_W-1:0] {
    KEY_ADD = 5'b1_0000,
    KEY_SUB = 5'b1_0001,
    KEY_EXE = 5'b1_0011,
    KEY_AND = 5'b1_0100,
    KEY_OR  = 5'b1_0101,
    KEY_CE  = 5'b1_0110,
    KEY_CLR = 5'b1_0111
  } key_t;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'd0,
    ST_OP_SET  = 2'd1,
    ST_ENTER_B = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  // True only for the four arithmetic/logic operators.
  function automatic logic is_op(input logic [OP_W-1:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB) ||
           (code == KEY_AND) || (code == KEY_OR);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad-detector to sequencer bus: digit/operator/control inputs and the
// display, state and overflow outputs.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic [DIGIT_W-1:0] num;
  logic [OP_W-1:0]    operation;
  logic               EXE;
  logic               CE;
  logic               CLR;
  logic               ok;
  logic [DATA_W-1:0]  display;
  logic [1:0]         state;
  logic               ovf;

  modport master (output num, operation, EXE, CE, CLR, ok,
                  input  display, state, ovf);
  modport slave  (input  num, operation, EXE, CE, CLR, ok,
                  output display, state, ovf);
endinterface

// File: rtl/calc_alu.sv
// Combinational 16-bit ALU; ovf is carry for ADD and borrow for SUB.
module calc_alu
  import calc_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_ovf
);

  logic [DATA_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    case (i_op)
      KEY_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_ovf    = w_sum[DATA_W];
      end
      KEY_SUB: begin
        o_result = i_a - i_b;
        o_ovf    = (i_a < i_b);
      end
      KEY_AND: o_result = i_a & i_b;
      KEY_OR:  o_result = i_a | i_b;
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Four-state calculator sequencer: collects two hex operands and an operator,
// supports chaining, and presents the entry or result on a registered display.
module calc_sequencer
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  calc_sequencer_if.slave bus
);

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_a, r_b, r_r, w_a_nxt, w_b_nxt, w_r_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [OP_W-1:0]     r_op, w_op_nxt, r_prev_op, w_prev_nxt;
  logic                r_ovf, w_ovf_nxt;
  logic [DATA_W-1:0]   r_display, w_display_nxt;
  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_ovf;
  logic                w_op_event;
  logic                w_room;

  calc_alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_op     (r_op),
    .o_result (w_alu_res),
    .o_ovf    (w_alu_ovf)
  );

  // An operator press is a valid code that differs from last cycle's level.
  assign w_op_event = is_op(bus.operation) && (bus.operation != r_prev_op);
  assign w_room     = (r_cnt < CNT_W'(MAX_DIGITS));

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_r_nxt     = r_r;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_ovf_nxt   = r_ovf;
    w_prev_nxt  = bus.operation;

    if (bus.CLR) begin
      w_state_nxt = ST_ENTER_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_r_nxt     = '0;
      w_cnt_nxt   = '0;
      w_op_nxt    = KEY_ADD;
      w_ovf_nxt   = 1'b0;
      w_prev_nxt  = '0;
    end else if (bus.CE) begin
      w_ovf_nxt = 1'b0;
      w_cnt_nxt = '0;
      case (r_state)
        ST_ENTER_A: w_a_nxt = '0;
        ST_OP_SET:  w_state_nxt = ST_ENTER_A;
        ST_ENTER_B: w_b_nxt = '0;
        ST_RESULT: begin
          w_a_nxt     = '0;
          w_state_nxt = ST_ENTER_A;
        end
        default: ;
      endcase
    end else if (bus.EXE) begin
      if (r_state == ST_ENTER_B) begin
        w_r_nxt     = w_alu_res;
        w_ovf_nxt   = w_alu_ovf;
        w_state_nxt = ST_RESULT;
      end
    end else if (bus.ok) begin
      case (r_state)
        ST_ENTER_A: if (w_room) begin
          w_a_nxt   = {r_a[DATA_W-DIGIT_W-1:0], bus.num};
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        ST_OP_SET: begin
          w_b_nxt     = DATA_W'(bus.num);
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_ENTER_B;
        end
        ST_ENTER_B: if (w_room) begin
          w_b_nxt   = {r_b[DATA_W-DIGIT_W-1:0], bus.num};
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        ST_RESULT: begin
          w_a_nxt     = DATA_W'(bus.num);
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_ENTER_A;
        end
        default: ;
      endcase
    end else if (w_op_event) begin
      w_op_nxt    = bus.operation;
      w_cnt_nxt   = '0;
      w_state_nxt = ST_OP_SET;
      if (r_state == ST_ENTER_B) begin
        w_a_nxt   = w_alu_res;
        w_ovf_nxt = w_alu_ovf;
      end else if (r_state == ST_RESULT) begin
        w_a_nxt = r_r;
      end
    end

    case (w_state_nxt)
      ST_ENTER_B: w_display_nxt = w_b_nxt;
      ST_RESULT:  w_display_nxt = w_r_nxt;
      default:    w_display_nxt = w_a_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ENTER_A;
      r_a       <= '0;
      r_b       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      r_op      <= KEY_ADD;
      r_prev_op <= '0;
      r_ovf     <= 1'b0;
      r_display <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_r       <= w_r_nxt;
      r_cnt     <= w_cnt_nxt;
      r_op      <= w_op_nxt;
      r_prev_op <= w_prev_nxt;
      r_ovf     <= w_ovf_nxt;
      r_display <= w_display_nxt;
    end
  end

  assign bus.display = r_display;
  assign bus.state   = r_state;
  assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: directed scenarios plus randomized key
// traffic, each cycle checked against a keypad-level calculator model.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_sequencer_if bus();

  calc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] disp;
    logic [1:0]  st;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Calculator model: mode, two operands, result, digits typed, pending op.
  int          m_mode;
  logic [15:0] m_a, m_b, m_r;
  int          m_digits;
  logic [4:0]  m_op, m_prev;
  logic        m_ovf;

  function automatic bit valid_op(input logic [4:0] c);
    return c == 5'h10 || c == 5'h11 || c == 5'h14 || c == 5'h15;
  endfunction

  function automatic logic [16:0] apply(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] op);
    int unsigned x, y;
    x = a; y = b;
    case (op)
      5'h10:   return 17'(x + y);
      5'h11:   return {(x < y), 16'((x + 65536 - y) % 65536)};
      5'h14:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  function void model_reset();
    m_mode = 0; m_a = 0; m_b = 0; m_r = 0; m_digits = 0;
    m_op = 5'h10; m_prev = 5'h00; m_ovf = 1'b0;
  endfunction

  function void model_step(input bit clr, input bit ce, input bit exe, input bit okv,
                           input logic [3:0] n, input logic [4:0] opv);
    bit ev;
    ev = valid_op(opv) && (opv != m_prev);
    m_prev = opv;
    if (clr) begin
      model_reset();
    end else if (ce) begin
      m_ovf = 0; m_digits = 0;
      if (m_mode == 2) m_b = 0;
      else if (m_mode != 1) m_a = 0;
      if (m_mode != 2) m_mode = 0;
    end else if (exe) begin
      if (m_mode == 2) begin
        {m_ovf, m_r} = apply(m_a, m_b, m_op);
        m_mode = 3;
      end
    end else if (okv) begin
      if (m_mode == 0 || m_mode == 2) begin
        if (m_digits < 4) begin
          if (m_mode == 0) m_a = 16'((int'(m_a) * 16 + int'(n)) % 65536);
          else             m_b = 16'((int'(m_b) * 16 + int'(n)) % 65536);
          m_digits++;
        end
      end else begin
        if (m_mode == 1) begin m_b = 16'(n); m_mode = 2; end
        else             begin m_a = 16'(n); m_mode = 0; end
        m_digits = 1;
      end
    end else if (ev) begin
      if (m_mode == 2) {m_ovf, m_a} = apply(m_a, m_b, m_op);
      if (m_mode == 3) m_a = m_r;
      m_op = opv; m_mode = 1; m_digits = 0;
    end
  endfunction

  function exp_t model_out();
    exp_t e;
    e.disp = (m_mode == 2) ? m_b : (m_mode == 3) ? m_r : m_a;
    e.st   = 2'(m_mode);
    e.ovf  = m_ovf;
    return e;
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual disp=%h st=%0d ovf=%b required disp=%h st=%0d ovf=%b",
               name, $time, act[18:3], act[2:1], act[0], exp[18:3], exp[2:1], exp[0]);
    end
  endtask

  task automatic drive(input bit clr, input bit ce, input bit exe, input bit okv,
                       input logic [3:0] n, input logic [4:0] opv);
    bus.CLR = clr; bus.CE = ce; bus.EXE = exe; bus.ok = okv;
    bus.num = n; bus.operation = opv;
  endtask

  task automatic step(input bit clr, input bit ce, input bit exe, input bit okv,
                      input logic [3:0] n, input logic [4:0] opv);
    @(negedge clk);
    drive(clr, ce, exe, okv, n, opv);
    model_step(clr, ce, exe, okv, n, opv);
    exp_q.push_back(model_out());
  endtask

  task automatic dig(input logic [3:0] n);
    step(0, 0, 0, 1, n, 5'h00);
  endtask

  task automatic key_op(input logic [4:0] opv);
    step(0, 0, 0, 0, 4'h0, opv);
  endtask

  task automatic expect_now(input string name, input logic [15:0] d,
                            input logic [1:0] s, input logic o);
    @(posedge clk);
    #2;
    check(name, {bus.display, bus.state, bus.ovf}, {d, s, o});
  endtask

  // Asynchronous reset pulse inside the low phase; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    #1;
    drive(0, 0, 0, 0, 4'h0, 5'h00);
    rst = 1'b1;
    #1;
    check("async_reset", {bus.display, bus.state, bus.ovf}, 19'd0);
    rst = 1'b0;
    model_reset();
    model_step(0, 0, 0, 0, 4'h0, 5'h00);
    exp_q.push_back(model_out());
  endtask

  // Monitor: compares every registered output update with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {bus.display, bus.state, bus.ovf}, e);
      end
    end
  end

  initial begin
    logic [4:0] cur_op;
    logic [4:0] op_pool [9];
    int         drain;
    op_pool = '{5'h10, 5'h11, 5'h14, 5'h15, 5'h00, 5'h13, 5'h16, 5'h17, 5'h12};

    drive(0, 0, 0, 0, 4'h0, 5'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bus.display, bus.state, bus.ovf}, 19'd0);
    @(negedge clk);
    rst = 1'b0;

    dig(4'h1);            expect_now("r29_d1",   16'h0001, 2'd0, 1'b0);
    dig(4'h2);            expect_now("r29_d2",   16'h0012, 2'd0, 1'b0);
    key_op(5'h10);        expect_now("r29_add",  16'h0012, 2'd1, 1'b0);
    dig(4'h3);            expect_now("r29_d3",   16'h0003, 2'd2, 1'b0);
    dig(4'h4);            expect_now("r29_d4",   16'h0034, 2'd2, 1'b0);
    step(0, 0, 1, 0, 4'h0, 5'h00);
    expect_now("r29_exe", 16'h0046, 2'd3, 1'b0);

    step(1, 0, 0, 0, 4'h0, 5'h00);
    repeat (4) dig(4'hF);
    key_op(5'h10);
    dig(4'h1);
    step(0, 0, 1, 0, 4'h0, 5'h00);
    expect_now("r30_carry", 16'h0000, 2'd3, 1'b1);
    dig(4'h2);
    key_op(5'h11);
    dig(4'h3);
    step(0, 0, 1, 0, 4'h0, 5'h00);
    expect_now("r30_borrow", 16'hFFFF, 2'd3, 1'b1);

    step(1, 0, 0, 0, 4'h0, 5'h00);
    for (int i = 1; i <= 5; i++) dig(4'(i));
    expect_now("r31_5th_ignored", 16'h1234, 2'd0, 1'b0);
    step(0, 1, 0, 0, 4'h0, 5'h00);
    expect_now("r31_ce", 16'h0000, 2'd0, 1'b0);

    dig(4'h5);
    key_op(5'h11);
    dig(4'h2);
    key_op(5'h10);        expect_now("r32_chain", 16'h0003, 2'd1, 1'b0);
    dig(4'h1);
    step(0, 0, 1, 0, 4'h0, 5'h00);
    expect_now("r32_exe", 16'h0004, 2'd3, 1'b0);

    step(1, 0, 0, 0, 4'h0, 5'h00);
    dig(4'h7);
    dig(4'h8);
    do_reset();
    dig(4'h9);            expect_now("r33_after_rst", 16'h0009, 2'd0, 1'b0);

    step(1, 0, 0, 0, 4'h0, 5'h00);
    dig(4'h1);
    key_op(5'h10);
    dig(4'h4);
    dig(4'h2);            expect_now("r34_b", 16'h0042, 2'd2, 1'b0);
    step(1, 0, 0, 1, 4'h5, 5'h00);
    expect_now("r34_clr_wins", 16'h0000, 2'd0, 1'b0);

    cur_op = 5'h00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        cur_op = 5'h00;
      end else begin
        if ($urandom_range(0, 99) < 20) begin
          if ($urandom_range(0, 9) == 0) cur_op = 5'($urandom);
          else cur_op = op_pool[$urandom_range(0, 8)];
        end
        step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6,
             $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 45,
             4'($urandom), cur_op);
      end
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 4'h0, cur_op);
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
